// File: rtl/drbg_sequence_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : drbg_sequence_transmitter
// Purpose  : On an accepted frame start, snapshots the DRBG sequence number
//            and streams it as PREAMBLE, 4 sequence bytes (MSB first) and a
//            CRC-8 byte. The packet is repeated REPEAT times back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module drbg_sequence_transmitter #(
  parameter logic [7:0] PREAMBLE = 8'hA5,
  parameter int         REPEAT   = 2,
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        init_done,
  input  logic [31:0] sequence_internal,
  input  logic        frame_start,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        packet_done,
  output logic [7:0]  overrun_count,
  output logic [31:0] sequence_sent
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_CRC      = 2'd3
  } state_t;

  localparam logic [3:0] c_last_rep = 4'(REPEAT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_idx;
  logic [1:0]  w_next_idx;
  logic [3:0]  r_rep;
  logic [3:0]  w_next_rep;
  logic [7:0]  r_crc;
  logic [31:0] r_seq;
  logic [7:0]  r_overrun;
  logic        r_done;
  logic        w_xfer;
  logic        w_start;
  logic        w_last;

  // CRC-8, MSB first over the whole word, zero init, no reflection, no final XOR
  function automatic logic [7:0] f_crc8(input logic [31:0] d);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb  = crc[7] ^ d[i];
      crc = {crc[6:0], 1'b0};
      if (fb) crc = crc ^ CRC_POLY;
    end
    return crc;
  endfunction

  assign w_xfer  = out_valid & out_ready;
  assign w_start = (r_state == S_IDLE) & frame_start & enable & init_done;
  assign w_last  = w_xfer & (r_state == S_CRC) & (r_rep == c_last_rep);

  // Next-state, counter and output-byte decode
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_rep   = r_rep;
    out_byte     = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next_state = S_PREAMBLE;
          w_next_rep   = 4'd0;
        end
      end
      S_PREAMBLE: begin
        out_byte = PREAMBLE;
        if (w_xfer) begin
          w_next_state = S_PAYLOAD;
          w_next_idx   = 2'd0;
        end
      end
      S_PAYLOAD: begin
        case (r_idx)
          2'd0:    out_byte = r_seq[31:24];
          2'd1:    out_byte = r_seq[23:16];
          2'd2:    out_byte = r_seq[15:8];
          default: out_byte = r_seq[7:0];
        endcase
        if (w_xfer) begin
          if (r_idx == 2'd3) w_next_state = S_CRC;
          else               w_next_idx   = r_idx + 2'd1;
        end
      end
      default: begin
        out_byte = r_crc;
        if (w_xfer) begin
          if (r_rep == c_last_rep) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_PREAMBLE;
            w_next_rep   = r_rep + 4'd1;
          end
        end
      end
    endcase
  end

  // State, snapshot, completion pulse and overrun counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= 2'd0;
      r_rep     <= 4'd0;
      r_crc     <= 8'h00;
      r_seq     <= 32'h0;
      r_done    <= 1'b0;
      r_overrun <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_rep   <= w_next_rep;
      r_done  <= w_last;
      if (w_start) begin
        r_seq <= sequence_internal;
        r_crc <= f_crc8(sequence_internal);
      end
      // any frame start outside IDLE is a dropped frame
      if (frame_start && (r_state != S_IDLE) && (r_overrun != 8'hFF))
        r_overrun <= r_overrun + 8'd1;
    end
  end

  assign out_valid     = (r_state != S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign packet_done   = r_done;
  assign overrun_count = r_overrun;
  assign sequence_sent = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_drbg_sequence_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_drbg_sequence_transmitter
// Purpose  : Directed bench with a byte scoreboard for the DRBG sequence
//            transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drbg_sequence_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        init_done;
  logic [31:0] sequence_internal;
  logic        frame_start;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        packet_done;
  logic [7:0]  overrun_count;
  logic [31:0] sequence_sent;

  int          vectors    = 0;
  int          miscompares = 0;
  int          done_cnt   = 0;
  logic [7:0]  sb[$];

  drbg_sequence_transmitter dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .init_done         (init_done),
    .sequence_internal (sequence_internal),
    .frame_start       (frame_start),
    .out_byte          (out_byte),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .busy              (busy),
    .packet_done       (packet_done),
    .overrun_count     (overrun_count),
    .sequence_sent     (sequence_sent)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // byte-wise CRC-8 reference (poly 0x07)
  function automatic logic [7:0] ref_crc(input logic [31:0] v);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 3; b >= 0; b--) begin
      c = c ^ v[8*b +: 8];
      for (int k = 0; k < 8; k++)
        c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_packet(input logic [31:0] v);
    for (int r = 0; r < 2; r++) begin
      sb.push_back(8'hA5);
      sb.push_back(v[31:24]);
      sb.push_back(v[23:16]);
      sb.push_back(v[15:8]);
      sb.push_back(v[7:0]);
      sb.push_back(ref_crc(v));
    end
  endtask

  task automatic pulse_fs(input logic [31:0] v);
    sequence_internal = v;
    frame_start       = 1'b1;
    tick();
    frame_start       = 1'b0;
  endtask

  // wait until busy drops; returns cycles taken
  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
    if (busy !== 1'b0) check({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  // scoreboard: compare every transferred byte
  always @(negedge clk) begin
    if (packet_done === 1'b1) done_cnt++;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $error("FAIL sb_unexpected: observed %h expected none", out_byte);
      end else begin
        automatic logic [7:0] e = sb.pop_front();
        assert (out_byte === e) else begin
          miscompares++;
          $error("FAIL sb_byte: observed %h expected %h", out_byte, e);
        end
      end
    end
  end

  initial begin
    int cyc;
    int d0;
    logic [31:0] snap;
    reset = 1'b1; enable = 1'b1; init_done = 1'b1; sequence_internal = 32'h0;
    frame_start = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(packet_done), 32'd0);
    check("rst_byte", 32'(out_byte), 32'd0);
    check("rst_ovr", 32'(overrun_count), 32'd0);
    check("rst_seq", sequence_sent, 32'd0);
    reset = 1'b0;
    tick();

    // basic packet, fixed expected bytes
    foreach (sb[i]) ;
    sb.push_back(8'hA5); sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00);
    sb.push_back(8'h01); sb.push_back(8'h07);
    sb.push_back(8'hA5); sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00);
    sb.push_back(8'h01); sb.push_back(8'h07);
    d0 = done_cnt;
    pulse_fs(32'h00000001);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_byte", 32'(out_byte), 32'hA5);
    wait_idle("p1", cyc);
    check("p1_cycles", 32'(cyc), 32'd12);
    check("p1_done_pulse", 32'(packet_done), 32'd1);
    check("p1_valid_off", 32'(out_valid), 32'd0);
    check("p1_seq", sequence_sent, 32'h00000001);
    tick();
    check("p1_done_one", 32'(packet_done), 32'd0);
    check("p1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("p1_sb_empty", 32'(sb.size()), 32'd0);

    // stall on the preamble
    out_ready = 1'b0;
    push_packet(32'h000000FF);
    pulse_fs(32'h000000FF);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_byte", 32'(out_byte), 32'hA5);
      tick();
    end
    check("stall_crc_model", 32'(ref_crc(32'h000000FF)), 32'hF3);
    out_ready = 1'b1;
    wait_idle("p2", cyc);
    check("p2_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    // four overruns during a packet
    push_packet(32'h12345678);
    pulse_fs(32'h12345678);
    for (int i = 0; i < 4; i++) pulse_fs(32'hDEADBEEF);
    wait_idle("p3", cyc);
    check("ovr4", 32'(overrun_count), 32'd4);
    check("p3_seq", sequence_sent, 32'h12345678);
    check("p3_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    // frame start on the final CRC transfer is dropped
    push_packet(32'hCAFEF00D);
    pulse_fs(32'hCAFEF00D);
    for (int i = 0; i < 11; i++) tick();
    check("crc_last_byte", 32'(out_byte), 32'(ref_crc(32'hCAFEF00D)));
    pulse_fs(32'h11111111);
    check("crc_fs_done", 32'(packet_done), 32'd1);
    check("crc_fs_busy", 32'(busy), 32'd0);
    check("ovr5", 32'(overrun_count), 32'd5);
    tick();
    check("crc_fs_idle", 32'(out_valid), 32'd0);

    // saturation: 260 more drops while stalled
    push_packet(32'h0BADC0DE);
    pulse_fs(32'h0BADC0DE);
    out_ready = 1'b0;
    for (int i = 0; i < 260; i++) pulse_fs(32'h55555555);
    check("ovr_sat", 32'(overrun_count), 32'hFF);
    out_ready = 1'b1;
    wait_idle("p5", cyc);
    check("p5_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    // ignored frame starts
    init_done = 1'b0;
    pulse_fs(32'h77777777);
    check("noinit_valid", 32'(out_valid), 32'd0);
    init_done = 1'b1; enable = 1'b0;
    pulse_fs(32'h77777777);
    check("noen_valid", 32'(out_valid), 32'd0);
    tick();
    check("noen_busy", 32'(busy), 32'd0);
    check("ign_ovr", 32'(overrun_count), 32'hFF);
    enable = 1'b1;

    // enable and init_done fall mid-packet
    d0 = done_cnt;
    push_packet(32'h89ABCDEF);
    pulse_fs(32'h89ABCDEF);
    enable = 1'b0; init_done = 1'b0;
    wait_idle("p6", cyc);
    check("p6_cycles", 32'(cyc), 32'd12);
    tick();
    check("p6_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("p6_sb_empty", 32'(sb.size()), 32'd0);
    enable = 1'b1; init_done = 1'b1;

    // sequence changes every cycle after the snapshot
    snap = 32'h3C5A96E1;
    push_packet(snap);
    pulse_fs(snap);
    for (int i = 0; i < 11; i++) begin
      sequence_internal = $urandom;
      tick();
    end
    wait_idle("p7", cyc);
    check("p7_seq", sequence_sent, snap);
    check("p7_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    // reset during the third payload byte
    d0 = done_cnt;
    sb.push_back(8'hA5); sb.push_back(8'hAA); sb.push_back(8'hBB);
    pulse_fs(32'hAABBCCDD);
    tick(); tick(); tick();
    check("mid_byte", 32'(out_byte), 32'hCC);
    reset = 1'b1; out_ready = 1'b0;
    tick();
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(packet_done), 32'd0);
    check("mid_seq_clr", sequence_sent, 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_sb_empty", 32'(sb.size()), 32'd0);
    push_packet(32'h01020304);
    pulse_fs(32'h01020304);
    check("restart_byte", 32'(out_byte), 32'hA5);
    wait_idle("p8", cyc);
    tick();
    check("p8_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("p8_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
